fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of instruction_memory. Owns the program counter and drives the memory byte address.
- Captures the returned 32-bit instruction into the IF/ID pipeline register for decode.
- Handles hazard-unit stalls and branch/jump redirects.
- Stops fetching on an all-zero instruction word, an out-of-range PC, or a misaligned redirect target.

---
 rtl/fetch_unit.sv | 150 +++++++++++++++
 tb/tb_fetch_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives instruction_memory and loads the IF/ID register.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter logic [63:0] RESET_PC     = 64'h0,
  parameter int unsigned IMEM_BYTES   = 4095,
  parameter bit          HALT_ON_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_target,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        if_id_valid,
  output logic [63:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic [63:0] if_id_pc_plus4,
  output logic        halted,
`ifdef FETCH_PERF_CNT_EN
  output logic [63:0] perf_fetched,
  output logic [63:0] perf_stall_cycles,
`endif
  output logic        fetch_err
);

  localparam int unsigned PC_W    = 64;
  localparam int unsigned INSTR_W = 32;
  localparam logic [PC_W-1:0] LAST_PC = PC_W'(IMEM_BYTES) - PC_W'(4);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               valid_q, valid_d;
  logic [PC_W-1:0]    id_pc_q, id_pc_d;
  logic [INSTR_W-1:0] id_instr_q, id_instr_d;
  logic [PC_W-1:0]    id_pc4_q, id_pc4_d;
  logic               err_q, err_d;
  logic [PC_W-1:0]    pc_plus4_c;
  logic               bad_target_c;

`ifdef FETCH_PERF_CNT_EN
  logic [63:0] fetched_q, fetched_d;
  logic [63:0] stalls_q, stalls_d;
`endif

  assign pc_plus4_c   = pc_q + PC_W'(4);
  assign bad_target_c = (redirect_target[1:0] != 2'b00) || (redirect_target > LAST_PC);

  // State and pipeline registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      id_pc_q    <= '0;
      id_instr_q <= '0;
      id_pc4_q   <= '0;
      err_q      <= 1'b0;
`ifdef FETCH_PERF_CNT_EN
      fetched_q  <= '0;
      stalls_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
      id_pc4_q   <= id_pc4_d;
      err_q      <= err_d;
`ifdef FETCH_PERF_CNT_EN
      fetched_q  <= fetched_d;
      stalls_q   <= stalls_d;
`endif
    end
  end

  // Next-state: redirect beats stall; stall beats range/zero checks and fetch
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    id_pc4_d   = id_pc4_q;
    err_d      = err_q;
`ifdef FETCH_PERF_CNT_EN
    fetched_d  = fetched_q;
    stalls_d   = stalls_q;
`endif
    case (state_q)
      ST_RUN: begin
        if (redirect_valid) begin
          valid_d = 1'b0;
          if (bad_target_c) begin
            state_d = ST_HALT;
            err_d   = 1'b1;
          end else begin
            pc_d = redirect_target;
          end
        end else if (stall) begin
`ifdef FETCH_PERF_CNT_EN
          stalls_d = stalls_q + 64'd1;
`endif
        end else if (pc_q > LAST_PC) begin
          state_d = ST_HALT;
          err_d   = 1'b1;
          valid_d = 1'b0;
        end else if (HALT_ON_ZERO && (imem_instr == '0)) begin
          state_d = ST_HALT;
          valid_d = 1'b0;
        end else begin
          valid_d    = 1'b1;
          id_pc_d    = pc_q;
          id_instr_d = imem_instr;
          id_pc4_d   = pc_plus4_c;
          pc_d       = pc_plus4_c;
`ifdef FETCH_PERF_CNT_EN
          fetched_d  = fetched_q + 64'd1;
`endif
        end
      end
      ST_HALT: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = ST_HALT;
        valid_d = 1'b0;
      end
    endcase
  end

  assign imem_addr      = pc_q;
  assign if_id_valid    = valid_q;
  assign if_id_pc       = id_pc_q;
  assign if_id_instr    = id_instr_q;
  assign if_id_pc_plus4 = id_pc4_q;
  assign halted         = (state_q == ST_HALT);
  assign fetch_err      = err_q;
`ifdef FETCH_PERF_CNT_EN
  assign perf_fetched      = fetched_q;
  assign perf_stall_cycles = stalls_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a combinational word-array instruction memory.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_target;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        if_id_valid;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic [63:0] if_id_pc_plus4;
  logic        halted;
  logic        fetch_err;
`ifdef FETCH_PERF_CNT_EN
  logic [63:0] perf_fetched;
  logic [63:0] perf_stall_cycles;
`endif

  logic [31:0] mem [0:1023];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_addr[11:2]];

  fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_instr      (imem_instr),
    .if_id_valid     (if_id_valid),
    .if_id_pc        (if_id_pc),
    .if_id_instr     (if_id_instr),
    .if_id_pc_plus4  (if_id_pc_plus4),
    .halted          (halted),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetched      (perf_fetched),
    .perf_stall_cycles (perf_stall_cycles),
`endif
    .fetch_err       (fetch_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = '0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[0] = 32'h00000013;
    mem[1] = 32'h00100093;
    mem[2] = 32'h00200113;

    // Straight-line fetch ending on a zero word
    do_reset();
    chk("rst_pc",    imem_addr, 64'h0);
    chk("rst_valid", 64'(if_id_valid), 64'h0);
    chk("rst_halt",  64'(halted), 64'h0);
    chk("rst_err",   64'(fetch_err), 64'h0);
    chk("rst_idpc",  if_id_pc, 64'h0);
    chk("rst_instr", 64'(if_id_instr), 64'h0);
    chk("rst_pc4",   if_id_pc_plus4, 64'h0);
    step();
    chk("c1_valid", 64'(if_id_valid), 64'h1);
    chk("c1_idpc",  if_id_pc, 64'h0);
    chk("c1_instr", 64'(if_id_instr), 64'h00000013);
    chk("c1_pc4",   if_id_pc_plus4, 64'h4);
    chk("c1_pc",    imem_addr, 64'h4);
    step();
    chk("c2_idpc",  if_id_pc, 64'h4);
    chk("c2_instr", 64'(if_id_instr), 64'h00100093);
    step();
    chk("c3_idpc",  if_id_pc, 64'h8);
    chk("c3_valid", 64'(if_id_valid), 64'h1);
    step();
    chk("c4_valid", 64'(if_id_valid), 64'h0);
    chk("c4_halt",  64'(halted), 64'h1);
    chk("c4_err",   64'(fetch_err), 64'h0);
    chk("c4_pc",    imem_addr, 64'hC);
    step();
    chk("c5_idpc_hold", if_id_pc, 64'h8);
    chk("c5_pc_hold",   imem_addr, 64'hC);

    // Stall holds PC and IF/ID
    for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + 32'(i);
    do_reset();
    step();
    step();
    chk("s0_idpc", if_id_pc, 64'h4);
    stall = 1'b1;
    step();
    chk("s1_idpc",  if_id_pc, 64'h4);
    chk("s1_pc",    imem_addr, 64'h8);
    chk("s1_valid", 64'(if_id_valid), 64'h1);
    chk("s1_instr", 64'(if_id_instr), 64'h1000_0001);
    step();
    chk("s2_idpc", if_id_pc, 64'h4);
    chk("s2_pc",   imem_addr, 64'h8);
    chk("s2_pc4",  if_id_pc_plus4, 64'h8);
    stall = 1'b0;
    step();
    chk("s3_idpc", if_id_pc, 64'h8);
    chk("s3_pc",   imem_addr, 64'hC);

    // Redirect overrides simultaneous stall and flushes
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 64'h20;
    step();
    chk("r1_pc",    imem_addr, 64'h20);
    chk("r1_valid", 64'(if_id_valid), 64'h0);
    stall = 1'b0;
    redirect_valid = 1'b0;
    step();
    chk("r2_idpc",  if_id_pc, 64'h20);
    chk("r2_valid", 64'(if_id_valid), 64'h1);
    chk("r2_instr", 64'(if_id_instr), 64'h1000_0008);
    chk("r2_pc",    imem_addr, 64'h24);

    // Misaligned redirect halts with error; later redirects ignored
    redirect_valid = 1'b1;
    redirect_target = 64'h22;
    step();
    chk("m1_halt",  64'(halted), 64'h1);
    chk("m1_err",   64'(fetch_err), 64'h1);
    chk("m1_valid", 64'(if_id_valid), 64'h0);
    redirect_target = 64'h0;
    step();
    redirect_valid = 1'b0;
    step();
    chk("m2_pc",   imem_addr, 64'h24);
    chk("m2_halt", 64'(halted), 64'h1);
    chk("m2_idpc", if_id_pc, 64'h20);

    // Reset out of HALT
    do_reset();
    chk("h_rst_pc",   imem_addr, 64'h0);
    chk("h_rst_halt", 64'(halted), 64'h0);
    chk("h_rst_err",  64'(fetch_err), 64'h0);

    // Redirect to IMEM_BYTES
    redirect_valid = 1'b1;
    redirect_target = 64'd4095;
    step();
    redirect_valid = 1'b0;
    chk("o1_halt", 64'(halted), 64'h1);
    chk("o1_err",  64'(fetch_err), 64'h1);

    // Aligned but one word past the last legal address
    do_reset();
    redirect_valid = 1'b1;
    redirect_target = 64'd4092;
    step();
    redirect_valid = 1'b0;
    chk("o2_halt", 64'(halted), 64'h1);
    chk("o2_err",  64'(fetch_err), 64'h1);
    chk("o2_pc",   imem_addr, 64'h0);

    // Last legal word fetched, then sequential PC runs out of range
    mem[1022] = 32'hDEAD_BEEF;
    do_reset();
    redirect_valid = 1'b1;
    redirect_target = 64'd4088;
    step();
    redirect_valid = 1'b0;
    chk("e1_pc",   imem_addr, 64'd4088);
    chk("e1_halt", 64'(halted), 64'h0);
    step();
    chk("e2_idpc",  if_id_pc, 64'd4088);
    chk("e2_instr", 64'(if_id_instr), 64'hDEAD_BEEF);
    chk("e2_pc",    imem_addr, 64'd4092);
    step();
    chk("e3_halt",  64'(halted), 64'h1);
    chk("e3_err",   64'(fetch_err), 64'h1);
    chk("e3_valid", 64'(if_id_valid), 64'h0);

`ifdef FETCH_PERF_CNT_EN
    // 5 fetches and 3 stall cycles
    do_reset();
    chk("p0_fetched", perf_fetched, 64'h0);
    chk("p0_stalls",  perf_stall_cycles, 64'h0);
    step();
    step();
    stall = 1'b1;
    step();
    step();
    step();
    stall = 1'b0;
    step();
    step();
    step();
    chk("p1_fetched", perf_fetched, 64'd5);
    chk("p1_stalls",  perf_stall_cycles, 64'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
